// File: rtl/lc3b_types.sv
`default_nettype none
// Shared LC-3b types: arbiter grant states and the cache-line / byte-mask
// containers exchanged on the memory ports.
package lc3b_types;

  localparam int LC3B_LINE_W = 128;
  localparam int LC3B_MASK_W = LC3B_LINE_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } lc3b_arb_state;

  typedef logic [LC3B_LINE_W-1:0] lc3b_line;
  typedef logic [LC3B_MASK_W-1:0] lc3b_line_mask;

endpackage
`default_nettype wire

// File: rtl/arb_streak_counter.sv
`default_nettype none
// Saturating count of back-to-back D-side completions seen while the I side waits.
// Rev 1.0
module arb_streak_counter #(
  parameter int MAX_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CNT_W = $clog2(MAX_COUNT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// Shares one downstream memory port between the I and D requesters with fixed
// D priority; ARB_ANTI_STARVE_EN adds a D-streak limit that forces an I grant.
// Rev 1.0
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int DATA_W       = 128,
  parameter int BE_W         = DATA_W / 8,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [15:0]       i_address,
  input  logic              i_action_stb,
  input  logic              i_action_cyc,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  output logic              i_retry,

  input  logic [15:0]       d_address,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_write,
  input  logic [BE_W-1:0]   d_byte_enable,
  input  logic              d_action_stb,
  input  logic              d_action_cyc,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              d_retry,

  output logic [15:0]       m_address,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_write,
  output logic [BE_W-1:0]   m_byte_enable,
  output logic              m_action_stb,
  output logic              m_action_cyc,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_resp,
  input  logic              m_retry,

  output logic              grant_i,
  output logic              grant_d
);

  lc3b_arb_state state;
  lc3b_arb_state next_state;

  logic req_i;
  logic req_d;
  logic streak_limit;

  assign req_i = i_action_stb & i_action_cyc;
  assign req_d = d_action_stb & d_action_cyc;

`ifdef ARB_ANTI_STARVE_EN
  logic d_done;
  logic streak_clr;
  logic streak_inc;

  assign d_done     = (state == ARB_GNT_D) && m_resp;
  assign streak_inc = d_done && req_i;
  assign streak_clr = ((state == ARB_IDLE) && (next_state == ARB_GNT_I)) || (d_done && !req_i);

  arb_streak_counter #(
    .MAX_COUNT(MAX_D_STREAK)
  ) u_streak (
    .clk     (clk),
    .reset   (reset),
    .clr     (streak_clr),
    .inc     (streak_inc),
    .at_limit(streak_limit)
  );
`else
  logic unused_streak_cfg;
  assign unused_streak_cfg = (MAX_D_STREAK > 0);
  assign streak_limit      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A completion or a cyc drop always passes through IDLE, so a stale strobe
  // held in the cycle after resp can never be granted twice.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: begin
        if (streak_limit && req_i) begin
          next_state = ARB_GNT_I;
        end else if (req_d) begin
          next_state = ARB_GNT_D;
        end else if (req_i) begin
          next_state = ARB_GNT_I;
        end
      end
      ARB_GNT_I: begin
        if (m_resp || !i_action_cyc) begin
          next_state = ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        if (m_resp || !d_action_cyc) begin
          next_state = ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    m_address     = '0;
    m_wdata       = '0;
    m_write       = 1'b0;
    m_byte_enable = '0;
    m_action_stb  = 1'b0;
    m_action_cyc  = 1'b0;
    i_resp        = 1'b0;
    i_retry       = 1'b0;
    d_resp        = 1'b0;
    d_retry       = 1'b0;
    case (state)
      ARB_GNT_I: begin
        m_address    = i_address;
        m_action_stb = i_action_stb;
        m_action_cyc = i_action_cyc;
        i_resp       = m_resp;
        i_retry      = m_retry & i_action_cyc;
      end
      ARB_GNT_D: begin
        m_address     = d_address;
        m_wdata       = d_wdata;
        m_write       = d_write;
        m_byte_enable = d_byte_enable;
        m_action_stb  = d_action_stb;
        m_action_cyc  = d_action_cyc;
        d_resp        = m_resp;
        d_retry       = m_retry & d_action_cyc;
      end
      default: ;
    endcase
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign grant_i = (state == ARB_GNT_I);
  assign grant_d = (state == ARB_GNT_D);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Directed scoreboard bench for mem_port_arbiter (default and ARB_ANTI_STARVE_EN builds).
module tb_mem_port_arbiter;
  import lc3b_types::*;

  localparam int DATA_W = LC3B_LINE_W;
  localparam int BE_W   = LC3B_MASK_W;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   i_address;
  logic          i_action_stb, i_action_cyc;
  lc3b_line      i_rdata;
  logic          i_resp, i_retry;
  logic [15:0]   d_address;
  lc3b_line      d_wdata;
  logic          d_write;
  lc3b_line_mask d_byte_enable;
  logic          d_action_stb, d_action_cyc;
  lc3b_line      d_rdata;
  logic          d_resp, d_retry;
  logic [15:0]   m_address;
  lc3b_line      m_wdata;
  logic          m_write;
  lc3b_line_mask m_byte_enable;
  logic          m_action_stb, m_action_cyc;
  lc3b_line      m_rdata;
  logic          m_resp, m_retry;
  logic          grant_i, grant_d;

  mem_port_arbiter #(.DATA_W(DATA_W), .BE_W(BE_W), .MAX_D_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_action_stb(i_action_stb), .i_action_cyc(i_action_cyc),
    .i_rdata(i_rdata), .i_resp(i_resp), .i_retry(i_retry),
    .d_address(d_address), .d_wdata(d_wdata), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_action_stb(d_action_stb), .d_action_cyc(d_action_cyc),
    .d_rdata(d_rdata), .d_resp(d_resp), .d_retry(d_retry),
    .m_address(m_address), .m_wdata(m_wdata), .m_write(m_write), .m_byte_enable(m_byte_enable),
    .m_action_stb(m_action_stb), .m_action_cyc(m_action_cyc),
    .m_rdata(m_rdata), .m_resp(m_resp), .m_retry(m_retry),
    .grant_i(grant_i), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit       side_d;
    lc3b_line data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input lc3b_line obs, input lc3b_line exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic nextcyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic respond(input bit side_d, input lc3b_line data);
    exp_t e;
    m_resp  = 1'b1;
    m_rdata = data;
    e.side_d = side_d;
    e.data   = data;
    sb.push_back(e);
  endtask

  task automatic resp_sample(input string tag);
    exp_t e;
    if (i_resp || d_resp) begin
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_resp"}, {126'd0, i_resp, d_resp}, '0);
      end else begin
        e = sb.pop_front();
        chk({tag, "_d_resp"}, {127'd0, d_resp}, {127'd0, e.side_d});
        chk({tag, "_i_resp"}, {127'd0, i_resp}, {127'd0, !e.side_d});
        chk({tag, "_rdata"}, e.side_d ? d_rdata : i_rdata, e.data);
      end
    end else begin
      chk({tag, "_resp_seen"}, {127'd0, (sb.size() != 0)}, '0);
    end
  endtask

  initial begin
    bit exp_i;
    reset = 1'b1;
    i_address = '0; i_action_stb = 1'b1; i_action_cyc = 1'b1;
    d_address = '0; d_wdata = '0; d_write = 1'b0; d_byte_enable = '0;
    d_action_stb = 1'b1; d_action_cyc = 1'b1;
    m_rdata = '0; m_resp = 1'b0; m_retry = 1'b1;
    #2;
    chk("rst_m_stb", {127'd0, m_action_stb}, '0);
    chk("rst_m_cyc", {127'd0, m_action_cyc}, '0);
    chk("rst_grants", {126'd0, grant_i, grant_d}, '0);
    chk("rst_retries", {126'd0, i_retry, d_retry}, '0);
    i_action_stb = 1'b0; i_action_cyc = 1'b0;
    d_action_stb = 1'b0; d_action_cyc = 1'b0;
    m_retry = 1'b0;
    #1 reset = 1'b0;

    // I-only read
    nextcyc();
    i_address = 16'h1230; i_action_stb = 1'b1; i_action_cyc = 1'b1;
    settle();
    chk("t1_c0_stb", {127'd0, m_action_stb}, '0);
    nextcyc(); settle();
    chk("t1_c1_grant_i", {127'd0, grant_i}, 128'd1);
    chk("t1_c1_stb", {127'd0, m_action_stb}, 128'd1);
    chk("t1_c1_addr", {112'd0, m_address}, 128'h1230);
    chk("t1_c1_write", {127'd0, m_write}, '0);
    nextcyc(); nextcyc(); nextcyc();
    respond(1'b0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233);
    settle();
    resp_sample("t1_c4");
    nextcyc();
    m_resp = 1'b0; i_action_stb = 1'b0; i_action_cyc = 1'b0;
    settle();
    chk("t1_c5_idle", {126'd0, grant_i, grant_d}, '0);

    // Simultaneous requests: D first, then I after the bubble
    nextcyc();
    i_address = 16'h2468; i_action_stb = 1'b1; i_action_cyc = 1'b1;
    d_address = 16'h4000; d_write = 1'b1; d_byte_enable = 16'h000F;
    d_wdata = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
    d_action_stb = 1'b1; d_action_cyc = 1'b1;
    nextcyc(); settle();
    chk("t2_c1_grants", {126'd0, grant_i, grant_d}, 128'd1);
    chk("t2_c1_write", {127'd0, m_write}, 128'd1);
    chk("t2_c1_be", {112'd0, m_byte_enable}, 128'h000F);
    chk("t2_c1_addr", {112'd0, m_address}, 128'h4000);
    chk("t2_c1_wdata", m_wdata, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555);
    nextcyc(); nextcyc();
    respond(1'b1, 128'h0);
    settle();
    resp_sample("t2_c3");
    nextcyc();
    m_resp = 1'b0; d_action_stb = 1'b0; d_action_cyc = 1'b0; d_write = 1'b0;
    settle();
    chk("t2_c4_idle", {126'd0, grant_i, grant_d}, '0);
    nextcyc(); settle();
    chk("t2_c5_grant_i", {126'd0, grant_i, grant_d}, 128'd2);
    chk("t2_c5_addr", {112'd0, m_address}, 128'h2468);
    chk("t2_c5_be", {112'd0, m_byte_enable}, '0);
    chk("t2_c5_wdata", m_wdata, '0);
    nextcyc();
    respond(1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    settle();
    resp_sample("t2_c6");
    nextcyc();
    m_resp = 1'b0; i_action_stb = 1'b0; i_action_cyc = 1'b0;
    settle();
    chk("t2_c7_idle", {126'd0, grant_i, grant_d}, '0);

    // Retry on D with I waiting; then abort of the following I grant
    nextcyc();
    d_address = 16'h0880; d_action_stb = 1'b1; d_action_cyc = 1'b1;
    i_address = 16'h0440; i_action_stb = 1'b1; i_action_cyc = 1'b1;
    nextcyc(); settle();
    chk("t3_c1_grant_d", {126'd0, grant_i, grant_d}, 128'd1);
    nextcyc();
    m_retry = 1'b1;
    settle();
    chk("t3_c2_retries", {126'd0, i_retry, d_retry}, 128'd1);
    chk("t3_c2_resps", {126'd0, i_resp, d_resp}, '0);
    nextcyc();
    m_retry = 1'b0;
    settle();
    chk("t3_c3_retries", {126'd0, i_retry, d_retry}, '0);
    chk("t3_c3_grant_d", {127'd0, grant_d}, 128'd1);
    nextcyc(); settle();
    chk("t3_c4_grant_d", {127'd0, grant_d}, 128'd1);
    nextcyc();
    respond(1'b1, 128'h5A5A_5A5A_5A5A_5A5A_A5A5_A5A5_A5A5_A5A5);
    settle();
    chk("t3_c5_grant_d", {127'd0, grant_d}, 128'd1);
    resp_sample("t3_c5");
    nextcyc();
    m_resp = 1'b0; d_action_stb = 1'b0; d_action_cyc = 1'b0;
    settle();
    chk("t3_c6_idle", {126'd0, grant_i, grant_d}, '0);
    nextcyc(); settle();
    chk("t4_c1_grant_i", {126'd0, grant_i, grant_d}, 128'd2);
    nextcyc(); nextcyc();
    i_action_stb = 1'b0; i_action_cyc = 1'b0;
    settle();
    chk("t4_c3_m_cyc", {127'd0, m_action_cyc}, '0);
    chk("t4_c3_grant_i", {127'd0, grant_i}, 128'd1);
    resp_sample("t4_c3");
    nextcyc(); settle();
    chk("t4_c4_idle", {126'd0, grant_i, grant_d}, '0);

    // Reset in the middle of a D grant
    nextcyc();
    d_address = 16'h5000; d_write = 1'b1; d_byte_enable = 16'hFFFF;
    d_action_stb = 1'b1; d_action_cyc = 1'b1;
    i_address = 16'h2000; i_action_stb = 1'b1; i_action_cyc = 1'b1;
    nextcyc(); settle();
    chk("t5_grant_d", {127'd0, grant_d}, 128'd1);
    #3 reset = 1'b1;
    d_action_stb = 1'b0; d_action_cyc = 1'b0; d_write = 1'b0;
    #1;
    chk("t5_rst_grants", {126'd0, grant_i, grant_d}, '0);
    chk("t5_rst_m_ctrl", {126'd0, m_action_stb, m_action_cyc}, '0);
    chk("t5_rst_m_addr", {112'd0, m_address}, '0);
    chk("t5_rst_m_write", {127'd0, m_write}, '0);
    chk("t5_rst_m_be", {112'd0, m_byte_enable}, '0);
    nextcyc();
    chk("t5_held_grant_i", {127'd0, grant_i}, '0);
    #2 reset = 1'b0;
    nextcyc(); settle();
    chk("t5_after_grant_i", {126'd0, grant_i, grant_d}, 128'd2);
    chk("t5_after_addr", {112'd0, m_address}, 128'h2000);
    nextcyc();
    respond(1'b0, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F);
    settle();
    resp_sample("t5_resp");
    nextcyc();
    m_resp = 1'b0;
    settle();
    chk("t5_idle", {126'd0, grant_i, grant_d}, '0);

    // Continuous D and I traffic
    d_address = 16'h6000; d_action_stb = 1'b1; d_action_cyc = 1'b1;
    for (int k = 0; k < 8; k++) begin
      nextcyc();
`ifdef ARB_ANTI_STARVE_EN
      exp_i = (k == 4);
`else
      exp_i = 1'b0;
`endif
      respond(!exp_i, lc3b_line'(k + 1) << 8);
      settle();
      chk($sformatf("t6_grant%0d", k), {126'd0, grant_i, grant_d}, exp_i ? 128'd2 : 128'd1);
      resp_sample($sformatf("t6_resp%0d", k));
      nextcyc();
      m_resp = 1'b0;
      settle();
      chk($sformatf("t6_bubble%0d", k), {126'd0, grant_i, grant_d}, '0);
    end
    d_action_stb = 1'b0; d_action_cyc = 1'b0;
    i_action_stb = 1'b0; i_action_cyc = 1'b0;
    nextcyc(); settle();

    chk("sb_empty", lc3b_line'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between the instruction-side and data-side requesters of the pipelined LC-3b core.
- Sits below the I-cache and D-cache miss interfaces. It uses the same stb/cyc/resp/retry handshake as the core's imem/dmem ports.
- Registered grant state machine with fixed data-side priority and one idle bubble between transactions. Optional anti-starvation limit for the instruction side.

Parameters:
- DATA_W, 128, line width of rdata/wdata in bits.
- BE_W, DATA_W/8, byte-enable width.
- MAX_D_STREAK, 4, consecutive D grants allowed while I is pending. Used only with ARB_ANTI_STARVE_EN.

Ports:
- clk  in  1  sole clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_address  in  16  I-side byte address.
- i_action_stb  in  1  I-side request strobe.
- i_action_cyc  in  1  I-side cycle-valid; held high for the whole transaction.
- i_rdata  out  DATA_W  I-side read data.
- i_resp  out  1  I-side completion.
- i_retry  out  1  I-side retry.
- d_address  in  16  D-side byte address.
- d_wdata  in  DATA_W  D-side write data.
- d_write  in  1  D-side write enable.
- d_byte_enable  in  BE_W  D-side byte mask.
- d_action_stb  in  1  D-side request strobe.
- d_action_cyc  in  1  D-side cycle-valid.
- d_rdata  out  DATA_W  D-side read data.
- d_resp  out  1  D-side completion.
- d_retry  out  1  D-side retry.
- m_address  out  16  downstream address.
- m_wdata  out  DATA_W  downstream write data.
- m_write  out  1  downstream write enable.
- m_byte_enable  out  BE_W  downstream byte mask.
- m_action_stb  out  1  downstream strobe.
- m_action_cyc  out  1  downstream cycle-valid.
- m_rdata  in  DATA_W  downstream read data.
- m_resp  in  1  downstream completion.
- m_retry  in  1  downstream retry.
- grant_i  out  1  I-side currently owns the port.
- grant_d  out  1  D-side currently owns the port.

Behaviour:
- **States:** IDLE, GNT_I, GNT_D, held in a registered 2-bit state.
- **Reset:** state=IDLE, streak counter=0. While reset is high, all outputs are 0: m_*, grant_*, *_resp, *_retry.
- **IDLE arbitration:**
  - req_x = x_action_stb & x_action_cyc.
  - If req_d, go to GNT_D; else if req_i, go to GNT_I; else stay in IDLE.
  - Grant takes effect the next cycle. Request at cycle N gives m_action_stb high at N+1.
- **In GNT_x:**
  - m_address, m_action_stb and m_action_cyc mirror requester x combinationally.
  - In GNT_D, m_wdata, m_write and m_byte_enable mirror the D-side inputs. In GNT_I they are 0.
  - m_rdata fans out to both i_rdata and d_rdata unconditionally.
  - x_resp = m_resp and x_retry = m_retry, gated by grant. The non-granted side sees resp=retry=0 and simply waits with stb held.
- **Completion:** m_resp in GNT_x returns state to IDLE next cycle. This gives a mandatory one-cycle bubble, so a stale stb is never re-granted. The requester must drop stb the cycle after resp.
- **Retry:** m_retry does not change state. The requester re-presents stb under the same grant.
- **Abort:** if x_action_cyc falls in GNT_x without m_resp, go to IDLE next cycle and forward nothing. m_action_cyc drops that same cycle via the mirror.
- **Simultaneous events:** m_resp and cyc-drop in the same cycle count as a completion; resp is forwarded.
- **Reset mid-transaction:** immediately IDLE with outputs 0. The outstanding downstream access is abandoned; downstream must tolerate a cyc drop.
- **grant_i / grant_d:** decoded from state; never both high.

Optional Feature:
ARB_ANTI_STARVE_EN:
- **Enabled:**
  - Streak counter (clog2(MAX_D_STREAK+1) bits) increments on each GNT_D completion while req_i=1.
  - It clears on any I grant, or on a D completion with req_i=0.
  - It saturates at MAX_D_STREAK.
  - In IDLE, if streak==MAX_D_STREAK and req_i, grant I even if req_d.
- **Disabled:** strict D priority. The counter logic is absent, and I can starve indefinitely under continuous D traffic.

Decomposition:
- lc3b_types gains:
  - lc3b_arb_state enum {ARB_IDLE, ARB_GNT_I, ARB_GNT_D};
  - lc3b_line (DATA_W data);
  - lc3b_line_mask (BE_W).
- Sub-module arb_streak_counter, instantiated only under ARB_ANTI_STARVE_EN. It is the saturating counter with clear and increment inputs and an at_limit output.
- Mux/gating logic stays in the top module.

Test Plan:
1. **I-only read:** i stb/cyc at cycle 0, address 0x1230. Expect m_action_stb=1 and m_address=0x1230 at cycle 1, m_write=0. With m_resp at cycle 4 and m_rdata=0xDEAD…, i_resp=1 at cycle 4 with that data, d_resp=0. State is IDLE at cycle 5.
2. **Simultaneous requests:** both at cycle 0, D write 0x4000 with byte mask 0x000F. D is granted at cycle 1 with m_write=1 and m_byte_enable=0x000F. After resp at cycle 3, IDLE at cycle 4, I granted at cycle 5.
3. **Retry:** D granted, m_retry at cycle 2, then m_resp at cycle 5. d_retry=1 only at cycle 2, grant_d stays high through cycle 5, i_retry stays 0.
4. **Abort:** I granted, i_action_cyc dropped at cycle 3 with no m_resp. m_action_cyc=0 at cycle 3 and IDLE at cycle 4; no i_resp.
5. **Reset mid-transaction:** assert reset asynchronously in GNT_D between edges. All m_* are 0 and grant_d=0 immediately. After release, a pending I request is granted one cycle later.
6. **Anti-starvation** (ARB_ANTI_STARVE_EN, MAX_D_STREAK=4): continuous D and I requests. Grants go D,D,D,D,I,D… With the macro off, they go D forever.
